// File: rtl/seq_mult32.sv
// Sequential 32x32 unsigned shift-add multiplier.
// It takes 32 steps per product and HI/LO hold the result until the next product completes.
module seq_mult32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        last_step;
  logic [32:0] sum;
  logic [63:0] acc_step;

  assign last_step = (cnt_q == 6'd31);

  // The carry out of the 33-bit sum becomes acc[63] after the right shift.
  assign sum      = {1'b0, acc_q[63:32]} + {1'b0, (mplier_q[0] ? mcand_q : 32'd0)};
  assign acc_step = {sum, acc_q[31:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (state_q == StRun) begin
      acc_d    = acc_step;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 6'd1;
      if (last_step) begin
        hi_d = acc_step[63:32];
        lo_d = acc_step[31:0];
      end
    end else if (start) begin
      mcand_d  = A;
      mplier_d = B;
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
    HI   = hi_q;
    LO   = lo_q;
  end

endmodule

// File: doc/seq_mult32.md
SEQ_MULT32 -- requirements
Module: seq_mult32

Interface
REQ-001 The block SHALL have these ports, with clock and reset first:
- clk  input  1  single rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled on the rising edge of clk.
- A  input  32  multiplicand, unsigned.
- B  input  32  multiplier, unsigned.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the product is valid.
- HI  output  32  upper 32 bits of the last completed product.
- LO  output  32  lower 32 bits of the last completed product.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-003 HI/LO SHALL be the data inputs of the downstream MUX2_32 write-back select; they SHALL stay stable between done pulses.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE. Encoding is free.
REQ-005 In IDLE or DONE, start=1 at an edge SHALL be accepted. On acceptance the block SHALL:
- latch A and B into internal registers;
- clear the 64-bit accumulator;
- load the 6-bit iteration counter with 0;
- go to RUN.
REQ-006 In IDLE, start=0 SHALL keep the block in IDLE. In DONE, start=0 SHALL return the block to IDLE.
REQ-007 RUN SHALL perform exactly one shift-add step per cycle, 32 steps in total:
- if the multiplier LSB is 1, add the multiplicand into the upper 32 bits of the accumulator, with carry kept in a 33-bit sum;
- shift the accumulator right by 1, bringing the carry into bit 63;
- shift the multiplier register right by 1;
- increment the counter.
REQ-008 After the 32nd RUN step the FSM SHALL enter DONE. In that same edge, HI and LO SHALL load accumulator bits [63:32] and [31:0].
REQ-009 Latency SHALL be fixed and independent of the operand values:
- start accepted at edge E0;
- busy=1 from after E0 through the edge E32;
- done=1 and HI/LO valid in the cycle after E32 (state DONE).
REQ-010 busy SHALL be 1 exactly in RUN. done SHALL be 1 exactly in DONE, for one cycle unless a new start is accepted there.
REQ-011 start asserted while in RUN SHALL be ignored. It SHALL not alter the operands, the counter or the result.
REQ-012 A and B SHALL only be sampled on the accepting edge. Changes to A and B during RUN SHALL not affect the result.
REQ-013 HI/LO SHALL hold the previous product throughout a new operation. They SHALL update only on the transition to DONE.
REQ-014 The product SHALL be the exact unsigned 64-bit result, with no overflow or truncation: {HI,LO} = A*B.
REQ-015 Back-to-back operation: start=1 during DONE SHALL be accepted. done SHALL then be 1 for that cycle only, and busy SHALL be 1 from the next cycle.
REQ-016 Operands of zero SHALL still take the full 32-step latency; no early termination.

Reset
REQ-017 When reset=1 at an edge, the block SHALL, regardless of state:
- go to IDLE;
- set busy=0 and done=0;
- set HI=0 and LO=0;
- clear the counter, accumulator and operand registers.
REQ-018 Reset SHALL take priority over start when both are 1 on the same edge.
REQ-019 Reset mid-operation SHALL abort the operation, and no done SHALL follow for it.
REQ-020 Outputs SHALL remain at their reset values until a start is accepted after reset deasserts.

Verification
REQ-021 Basic multiply: reset, then A=3, B=5, start pulse -> busy high for 32 cycles, then done=1 with HI=0x00000000, LO=0x0000000F.
REQ-022 Maximum operands: A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at done.
REQ-023 Operand isolation: A=0x00010000, B=0x00010000, then during RUN set A=7, B=9 and pulse start -> done at the original cycle count with HI=0x00000001, LO=0x00000000.
REQ-024 Reset mid-operation: A=32767, B=16383, start, then reset at the 10th RUN cycle -> busy=0, HI=LO=0, no done for 40 cycles.
REQ-025 Back-to-back: A=32767, B=16383, then start held during DONE with A=2, B=0x80000000:
- first done gives HI=0x00000000, LO=0x1FFF4001;
- HI/LO stay 0x00000000/0x1FFF4001 during the second run;
- second done 33 cycles later gives HI=0x00000001, LO=0x00000000.
REQ-026 Zero operand: A=0, B=0x12345678 -> full 32-cycle busy, then done with HI=LO=0.
